// File: rtl/sprite_row_fetch.sv
// sprite_row_fetch
// Per-line sprite front end. On every line_start_i it walks object RAM in
// ascending index order, selects the entries that intersect the requested
// line, fetches the matching 16-pixel row from the graphics ROM and pushes
// it to the sprite line buffer write port.
//
// Ports
//   clk_i, reset_i         clock, synchronous active-high reset
//   line_start_i           one-cycle pulse, begin scan for next_line_i
//   next_line_i[8:0]       line being prepared (sampled on line_start_i)
//   obj_addr_o/obj_data_i  object RAM read port, data valid one cycle later
//   rom_req_o/rom_addr_o   ROM request, held with a stable address until ack
//   rom_ack_i/rom_data_i   one-cycle acknowledge with the 64-bit row
//   lb_*_o                 line buffer write port, lb_we_o a one-cycle strobe
//   lb_idle_i              line buffer can accept a new row
//   busy_o                 scan in progress
//   overflow_o             previous scan was cut short by a new line_start_i
module sprite_row_fetch #(
    parameter int NUM_SPRITES = 128,
    parameter int OBJ_AW      = 7
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              line_start_i,
    input  logic [8:0]        next_line_i,
    output logic [OBJ_AW-1:0] obj_addr_o,
    input  logic [63:0]       obj_data_i,
    output logic              rom_req_o,
    output logic [19:0]       rom_addr_o,
    input  logic              rom_ack_i,
    input  logic [63:0]       rom_data_i,
    output logic [63:0]       lb_bitplanes_o,
    output logic              lb_flip_o,
    output logic [3:0]        lb_color_o,
    output logic [9:0]        lb_pos_o,
    output logic              lb_we_o,
    input  logic              lb_idle_i,
    output logic              busy_o,
    output logic              overflow_o
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_READ     = 3'd1,
        S_OBJ_WAIT = 3'd2,
        S_CHECK    = 3'd3,
        S_ROM      = 3'd4,
        S_LB_WAIT  = 3'd5,
        S_NEXT     = 3'd6
    } state_e;

    localparam logic [OBJ_AW-1:0] LAST_IDX = OBJ_AW'(NUM_SPRITES - 1);
    localparam logic [OBJ_AW-1:0] IDX_ONE  = OBJ_AW'(1);
    localparam logic [OBJ_AW-1:0] IDX_ZERO = {OBJ_AW{1'b0}};

    state_e            state_q, state_d;
    logic [8:0]        line_q, line_d;
    logic [OBJ_AW-1:0] idx_q, idx_d;
    logic [OBJ_AW-1:0] obj_addr_q, obj_addr_d;
    logic [42:0]       obj_q, obj_d;
    logic              rom_req_q, rom_req_d;
    logic [19:0]       rom_addr_q, rom_addr_d;
    logic [63:0]       data_q, data_d;
    logic [63:0]       lb_bitplanes_q, lb_bitplanes_d;
    logic              lb_flip_q, lb_flip_d;
    logic [3:0]        lb_color_q, lb_color_d;
    logic [9:0]        lb_pos_q, lb_pos_d;
    logic              lb_we_q, lb_we_d;
    logic              busy_q, busy_d;
    logic              overflow_q, overflow_d;

    logic [8:0]  row_s;
    logic [7:0]  height_s;
    logic        hit_s;
    logic [7:0]  flip_row_s;
    logic [6:0]  r_s;
    logic [15:0] tile_s;
    logic        abort_s;
    logic        unused_s;

    assign abort_s  = line_start_i && (state_q != S_IDLE);
    assign unused_s = ^{obj_data_i[63:43], flip_row_s[7]};

    // Row selection for the latched object entry: 9-bit wrapped row,
    // height 16<<h, optional vertical flip, and ROM tile/row address.
    always_comb begin
        row_s      = line_q - obj_q[8:0];
        height_s   = 8'd16 << obj_q[10:9];
        hit_s      = (row_s < {1'b0, height_s});
        flip_row_s = height_s - 8'd1 - {1'b0, row_s[6:0]};
        if (obj_q[42]) begin
            r_s = flip_row_s[6:0];
        end else begin
            r_s = row_s[6:0];
        end
        tile_s = obj_q[36:21] + {13'd0, r_s[6:4]};
    end

    // Next-state and next-output logic for the scan FSM.
    always_comb begin
        state_d        = state_q;
        line_d         = line_q;
        idx_d          = idx_q;
        obj_addr_d     = obj_addr_q;
        obj_d          = obj_q;
        rom_req_d      = rom_req_q;
        rom_addr_d     = rom_addr_q;
        data_d         = data_q;
        lb_bitplanes_d = lb_bitplanes_q;
        lb_flip_d      = lb_flip_q;
        lb_color_d     = lb_color_q;
        lb_pos_d       = lb_pos_q;
        lb_we_d        = 1'b0;
        overflow_d     = overflow_q;
        if (abort_s) begin
            // A new line arrives mid-scan: drop any pending ROM request
            // (a later ack finds us outside S_ROM and is ignored) and restart.
            state_d    = S_READ;
            line_d     = next_line_i;
            idx_d      = IDX_ZERO;
            obj_addr_d = IDX_ZERO;
            rom_req_d  = 1'b0;
            overflow_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (line_start_i) begin
                        state_d    = S_READ;
                        line_d     = next_line_i;
                        idx_d      = IDX_ZERO;
                        obj_addr_d = IDX_ZERO;
                        overflow_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_READ: begin
                    state_d = S_OBJ_WAIT;
                end
                S_OBJ_WAIT: begin
                    obj_d   = obj_data_i[42:0];
                    state_d = S_CHECK;
                end
                S_CHECK: begin
                    if (hit_s) begin
                        rom_req_d  = 1'b1;
                        rom_addr_d = {tile_s, r_s[3:0]};
                        state_d    = S_ROM;
                    end else begin
                        state_d = S_NEXT;
                    end
                end
                S_ROM: begin
                    if (rom_ack_i) begin
                        rom_req_d = 1'b0;
                        // Write straight through when the buffer is already idle.
                        if (lb_idle_i) begin
                            lb_we_d        = 1'b1;
                            lb_bitplanes_d = rom_data_i;
                            lb_flip_d      = obj_q[41];
                            lb_color_d     = obj_q[40:37];
                            lb_pos_d       = obj_q[20:11];
                            state_d        = S_NEXT;
                        end else begin
                            data_d  = rom_data_i;
                            state_d = S_LB_WAIT;
                        end
                    end else begin
                        state_d = S_ROM;
                    end
                end
                S_LB_WAIT: begin
                    if (lb_idle_i) begin
                        lb_we_d        = 1'b1;
                        lb_bitplanes_d = data_q;
                        lb_flip_d      = obj_q[41];
                        lb_color_d     = obj_q[40:37];
                        lb_pos_d       = obj_q[20:11];
                        state_d        = S_NEXT;
                    end else begin
                        state_d = S_LB_WAIT;
                    end
                end
                S_NEXT: begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d      = idx_q + IDX_ONE;
                        obj_addr_d = idx_q + IDX_ONE;
                        state_d    = S_READ;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= S_IDLE;
            line_q         <= 9'd0;
            idx_q          <= IDX_ZERO;
            obj_addr_q     <= IDX_ZERO;
            obj_q          <= 43'd0;
            rom_req_q      <= 1'b0;
            rom_addr_q     <= 20'd0;
            data_q         <= 64'd0;
            lb_bitplanes_q <= 64'd0;
            lb_flip_q      <= 1'b0;
            lb_color_q     <= 4'd0;
            lb_pos_q       <= 10'd0;
            lb_we_q        <= 1'b0;
            busy_q         <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            line_q         <= line_d;
            idx_q          <= idx_d;
            obj_addr_q     <= obj_addr_d;
            obj_q          <= obj_d;
            rom_req_q      <= rom_req_d;
            rom_addr_q     <= rom_addr_d;
            data_q         <= data_d;
            lb_bitplanes_q <= lb_bitplanes_d;
            lb_flip_q      <= lb_flip_d;
            lb_color_q     <= lb_color_d;
            lb_pos_q       <= lb_pos_d;
            lb_we_q        <= lb_we_d;
            busy_q         <= busy_d;
            overflow_q     <= overflow_d;
        end
    end

    assign obj_addr_o     = obj_addr_q;
    assign rom_req_o      = rom_req_q;
    assign rom_addr_o     = rom_addr_q;
    assign lb_bitplanes_o = lb_bitplanes_q;
    assign lb_flip_o      = lb_flip_q;
    assign lb_color_o     = lb_color_q;
    assign lb_pos_o       = lb_pos_q;
    assign lb_we_o        = lb_we_q;
    assign busy_o         = busy_q;
    assign overflow_o     = overflow_q;

endmodule
